// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: command opcodes, ALU
// operation encodings, the FSM state encoding and the decoded ALU control
// bundle.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   // Command opcodes
   localparam logic [2:0] OPC_AND  = 3'b000;
   localparam logic [2:0] OPC_OR   = 3'b001;
   localparam logic [2:0] OPC_ADD  = 3'b010;
   localparam logic [2:0] OPC_SUB  = 3'b011;
   localparam logic [2:0] OPC_SLT  = 3'b100;
   localparam logic [2:0] OPC_NOR  = 3'b101;
   localparam logic [2:0] OPC_NAND = 3'b110;
   localparam logic [2:0] OPC_MUL  = 3'b111;

   // ALU op field encodings
   localparam logic [1:0] ALU_OP_AND = 2'b00;
   localparam logic [1:0] ALU_OP_OR  = 2'b01;
   localparam logic [1:0] ALU_OP_ADD = 2'b10;
   localparam logic [1:0] ALU_OP_SLT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Decoded ALU controls; binvert doubles as the ALU carry-in.
   typedef struct packed {
      logic       ainvert;
      logic       binvert;
      logic [1:0] op;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_seq_decode
// Combinational opcode -> ALU control decode. SUB/SLT use B inversion with
// carry-in 1 (two's complement); NOR/NAND use De Morgan on inverted inputs.
// MUL decodes to a plain ADD, which is what each shift-add step needs.
// Ports:
//   i_opcode  in   3  command opcode
//   o_ctrl    out  4  {ainvert, binvert, op}
// -----------------------------------------------------------------------------
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [2:0] i_opcode,
   output alu_ctrl_t  o_ctrl
);

   always_comb begin
      // NOTE: default assigned before the case so no path leaves o_ctrl
      // unassigned, which would otherwise infer a latch.
      o_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: ALU_OP_AND};
      case (i_opcode)
         OPC_AND:  o_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: ALU_OP_AND};
         OPC_OR:   o_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: ALU_OP_OR};
         OPC_ADD:  o_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: ALU_OP_ADD};
         OPC_SUB:  o_ctrl = '{ainvert: 1'b0, binvert: 1'b1, op: ALU_OP_ADD};
         OPC_SLT:  o_ctrl = '{ainvert: 1'b0, binvert: 1'b1, op: ALU_OP_SLT};
         OPC_NOR:  o_ctrl = '{ainvert: 1'b1, binvert: 1'b1, op: ALU_OP_AND};
         OPC_NAND: o_ctrl = '{ainvert: 1'b1, binvert: 1'b1, op: ALU_OP_OR};
         OPC_MUL:  o_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: ALU_OP_ADD};
         default:  ;
      endcase
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Command front-end and result stage for an external 8-bit ripple ALU.
// A command (opcode, A, B) is accepted on cmd_valid && cmd_ready, the
// operands and opcode are registered, the ALU is driven for one EXEC cycle
// and its result/zero/overflow are captured and offered on a rsp handshake.
//
// Optional feature macro: ALU_CMD_SEQ_MUL_EN
//   defined   : opcode 111 is an 8-step shift-add multiply using ALU ADDs.
//   undefined : opcode 111 completes immediately with rsp_err=1, result 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready == IDLE)
//   cmd_opcode, cmd_a, cmd_b   command opcode and operands
//   alu_src1/alu_src2          ALU operands (0 outside EXEC/MUL)
//   alu_ainvert/alu_binvert    ALU invert controls (binvert = carry-in)
//   alu_op                     ALU op select
//   alu_result/zero/overflow   ALU outputs
//   rsp_valid/rsp_ready        response handshake (held until accepted)
//   rsp_result/zero/overflow   captured response
//   rsp_err                    unsupported opcode
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_src1,
   output logic [WIDTH-1:0] alu_src2,
   output logic             alu_ainvert,
   output logic             alu_binvert,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_err
);

   state_e           r_state, w_state_next;
   logic [2:0]       r_opcode;
   logic [WIDTH-1:0] r_a, r_b;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_zero, r_rsp_overflow, r_rsp_err;
   logic             w_accept;
   alu_ctrl_t        w_dec;

`ifdef ALU_CMD_SEQ_MUL_EN
   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Shift-add state: running product, shifted multiplicand, multiplier.
   logic [WIDTH-1:0] r_p, r_m, r_q;
   logic [CNT_W-1:0] r_cnt;
`endif

   assign cmd_ready = (r_state == ST_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;
   assign rsp_valid = (r_state == ST_DONE);

   // Controls come from the registered opcode, never the live command bus.
   alu_seq_decode u_decode (
      .i_opcode (r_opcode),
      .o_ctrl   (w_dec)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next state and ALU drive
   always_comb begin
      w_state_next = r_state;
      alu_src1     = '0;
      alu_src2     = '0;
      alu_ainvert  = 1'b0;
      alu_binvert  = 1'b0;
      alu_op       = ALU_OP_AND;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
`ifdef ALU_CMD_SEQ_MUL_EN
               w_state_next = (cmd_opcode == OPC_MUL) ? ST_MUL : ST_EXEC;
`else
               w_state_next = (cmd_opcode == OPC_MUL) ? ST_DONE : ST_EXEC;
`endif
            end
         end
         ST_EXEC: begin
            alu_src1     = r_a;
            alu_src2     = r_b;
            alu_ainvert  = w_dec.ainvert;
            alu_binvert  = w_dec.binvert;
            alu_op       = w_dec.op;
            w_state_next = ST_DONE;
         end
`ifdef ALU_CMD_SEQ_MUL_EN
         ST_MUL: begin
            alu_src1 = r_p;
            alu_src2 = r_q[0] ? r_m : '0;
            alu_op   = ALU_OP_ADD;
            // Always runs all WIDTH steps, even once Q has drained to zero.
            if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (rsp_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand, step and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode       <= OPC_AND;
         r_a            <= '0;
         r_b            <= '0;
         r_rsp_result   <= '0;
         r_rsp_zero     <= 1'b0;
         r_rsp_overflow <= 1'b0;
         r_rsp_err      <= 1'b0;
`ifdef ALU_CMD_SEQ_MUL_EN
         r_p            <= '0;
         r_m            <= '0;
         r_q            <= '0;
         r_cnt          <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_opcode  <= cmd_opcode;
                  r_a       <= cmd_a;
                  r_b       <= cmd_b;
                  r_rsp_err <= 1'b0;
`ifdef ALU_CMD_SEQ_MUL_EN
                  r_p       <= '0;
                  r_m       <= cmd_a;
                  r_q       <= cmd_b;
                  r_cnt     <= '0;
`else
                  if (cmd_opcode == OPC_MUL) begin
                     r_rsp_result   <= '0;
                     r_rsp_zero     <= 1'b0;
                     r_rsp_overflow <= 1'b0;
                     r_rsp_err      <= 1'b1;
                  end
`endif
               end
            end
            ST_EXEC: begin
               r_rsp_result   <= alu_result;
               r_rsp_zero     <= alu_zero;
               r_rsp_overflow <= alu_overflow;
            end
`ifdef ALU_CMD_SEQ_MUL_EN
            ST_MUL: begin
               r_p   <= alu_result;
               r_m   <= r_m << 1;
               r_q   <= r_q >> 1;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_rsp_result   <= alu_result;
                  r_rsp_zero     <= alu_zero;
                  r_rsp_overflow <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign rsp_result   = r_rsp_result;
   assign rsp_zero     = r_rsp_zero;
   assign rsp_overflow = r_rsp_overflow;
   assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer with a behavioural 8-bit ripple ALU attached.
// A transaction-level model predicts cmd_ready, rsp_valid, response contents
// and ALU drive every cycle; directed commands also carry hand-computed
// expected values. Honours ALU_CMD_SEQ_MUL_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

   logic       clk, rst_n;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_opcode;
   logic [7:0] cmd_a, cmd_b;
   logic [7:0] alu_src1, alu_src2, alu_result;
   logic       alu_ainvert, alu_binvert, alu_zero, alu_overflow;
   logic [1:0] alu_op;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_zero, rsp_overflow, rsp_err;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_cmd_sequencer #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .alu_ainvert  (alu_ainvert),
      .alu_binvert  (alu_binvert),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ripple ALU ----------------
   logic [7:0] alu_a_eff, alu_b_eff, alu_sum;
   logic       alu_ovf;
   always_comb begin
      alu_a_eff    = alu_ainvert ? ~alu_src1 : alu_src1;
      alu_b_eff    = alu_binvert ? ~alu_src2 : alu_src2;
      alu_sum      = alu_a_eff + alu_b_eff + {7'b0, alu_binvert};
      alu_ovf      = (alu_a_eff[7] == alu_b_eff[7]) && (alu_sum[7] != alu_a_eff[7]);
      case (alu_op)
         2'b00:   alu_result = alu_a_eff & alu_b_eff;
         2'b01:   alu_result = alu_a_eff | alu_b_eff;
         2'b10:   alu_result = alu_sum;
         default: alu_result = {7'b0, alu_sum[7] ^ alu_ovf};
      endcase
      alu_zero     = (alu_result == 8'h00);
      alu_overflow = alu_ovf;
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] result;
      logic       zero;
      logic       ovf;
      logic       err;
   } rsp_t;

   function automatic logic add_ovf(input logic [7:0] x, input logic [7:0] y, input logic cin);
      logic [7:0] s;
      s = x + y + {7'b0, cin};
      return (x[7] == y[7]) && (s[7] != x[7]);
   endfunction

   function automatic rsp_t model_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      rsp_t r;
      r = '0;
      case (op)
         3'd0: begin r.result = a & b;  r.ovf = add_ovf(a, b, 1'b0);   end
         3'd1: begin r.result = a | b;  r.ovf = add_ovf(a, b, 1'b0);   end
         3'd2: begin r.result = a + b;  r.ovf = add_ovf(a, b, 1'b0);   end
         3'd3: begin r.result = a - b;  r.ovf = add_ovf(a, ~b, 1'b1);  end
         3'd4: begin
            r.result = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            r.ovf    = add_ovf(a, ~b, 1'b1);
         end
         3'd5: begin r.result = ~(a | b); r.ovf = add_ovf(~a, ~b, 1'b1); end
         3'd6: begin r.result = ~(a & b); r.ovf = add_ovf(~a, ~b, 1'b1); end
         default: begin
`ifdef ALU_CMD_SEQ_MUL_EN
            r.result = 8'((int'(a) * int'(b)) & 255);
`else
            r.err = 1'b1;
`endif
         end
      endcase
      r.zero = !r.err && (r.result == 8'h00);
      return r;
   endfunction

   // Cycles from the accept edge until the response is visible.
   function automatic int lat_of(input logic [2:0] op);
`ifdef ALU_CMD_SEQ_MUL_EN
      return (op == 3'd7) ? 8 : 1;
`else
      return (op == 3'd7) ? 0 : 1;
`endif
   endfunction

   // {ainvert, binvert, op} required while a single-cycle op executes.
   function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
      case (op)
         3'd0: return 4'b0000;
         3'd1: return 4'b0001;
         3'd2: return 4'b0010;
         3'd3: return 4'b0110;
         3'd4: return 4'b0111;
         3'd5: return 4'b1100;
         3'd6: return 4'b1101;
         default: return 4'b0010;
      endcase
   endfunction

   logic       m_busy, m_valid;
   int         m_wait;
   logic [2:0] m_op;
   logic [7:0] m_a, m_b;
   rsp_t       m_rsp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_wait  <= 0;
      end else if (m_valid) begin
         if (rsp_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
         end
      end else if (m_busy) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_valid <= 1'b1;
      end else if (cmd_valid) begin
         m_op    <= cmd_opcode;
         m_a     <= cmd_a;
         m_b     <= cmd_b;
         m_rsp   <= model_rsp(cmd_opcode, cmd_a, cmd_b);
         m_busy  <= 1'b1;
         m_wait  <= lat_of(cmd_opcode);
         m_valid <= (lat_of(cmd_opcode) == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         check("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
         check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         if (m_valid) begin
            check("rsp_result",   32'(rsp_result),   32'(m_rsp.result));
            check("rsp_zero",     32'(rsp_zero),     32'(m_rsp.zero));
            check("rsp_overflow", 32'(rsp_overflow), 32'(m_rsp.ovf));
            check("rsp_err",      32'(rsp_err),      32'(m_rsp.err));
         end
         if (m_busy && !m_valid) begin
            if (m_op == 3'd7) begin
               // Step k adds the B[k]-weighted multiplicand to the partial product.
               int k, pp, add;
               k   = 8 - m_wait;
               pp  = (int'(m_a) * (int'(m_b) & ((1 << k) - 1))) & 255;
               add = m_b[k] ? ((int'(m_a) << k) & 255) : 0;
               check("mul_src1", 32'(alu_src1), 32'(pp));
               check("mul_src2", 32'(alu_src2), 32'(add));
               check("mul_ctrl", 32'({alu_ainvert, alu_binvert, alu_op}), 32'(4'b0010));
            end else begin
               check("exec_src1", 32'(alu_src1), 32'(m_a));
               check("exec_src2", 32'(alu_src2), 32'(m_b));
               check("exec_ctrl", 32'({alu_ainvert, alu_binvert, alu_op}), 32'(exp_ctrl(m_op)));
            end
         end else begin
            check("alu_idle", 32'({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op}), 32'(0));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ez, input logic eo, input logic ee,
                         input int elat, input string nm);
      int n;
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check({nm, ".ready_wait"}, 32'(cmd_ready), 32'(1));
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (op == 3'b010 && elat == 1) begin
         check({nm, ".exec_op"},  32'(alu_op),      32'(2'b10));
         check({nm, ".exec_binv"}, 32'(alu_binvert), 32'(0));
      end
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      check({nm, ".latency"},  32'(n),            32'(elat));
      check({nm, ".result"},   32'(rsp_result),   32'(er));
      check({nm, ".zero"},     32'(rsp_zero),     32'(ez));
      check({nm, ".overflow"}, 32'(rsp_overflow), 32'(eo));
      check({nm, ".err"},      32'(rsp_err),      32'(ee));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      #1;
      check("reset.cmd_ready", 32'(cmd_ready), 32'(1));
      check("reset.rsp", 32'({rsp_valid, rsp_result, rsp_zero, rsp_overflow, rsp_err}), 32'(0));
      check("reset.alu", 32'({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op}), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_cmd(3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1, "add_7f_01");
      do_cmd(3'b011, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1, "sub_05_05");
      do_cmd(3'b100, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1, "slt_80_01");
      do_cmd(3'b100, 8'h01, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1, "slt_01_80");
      do_cmd(3'b101, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1, "nor_f0_0f");
      do_cmd(3'b110, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1, "nand_ff_0f");
      do_cmd(3'b000, 8'hAA, 8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0, 1, "and_aa_0f");
      do_cmd(3'b001, 8'hAA, 8'h0F, 8'hAF, 1'b0, 1'b0, 1'b0, 1, "or_aa_0f");
`ifdef ALU_CMD_SEQ_MUL_EN
      do_cmd(3'b111, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0, 8, "mul_0d_0b");
      do_cmd(3'b111, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8, "mul_10_10");
`else
      do_cmd(3'b111, 8'h0D, 8'h0B, 8'h00, 1'b0, 1'b0, 1'b1, 0, "mul_disabled");
`endif

      // Backpressure: response held 5 cycles while another command waits.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 3'b001; cmd_a = 8'h12; cmd_b = 8'h34;
      @(posedge clk); #1;
      cmd_opcode = 3'b010; cmd_a = 8'h03; cmd_b = 8'h04;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp.result", 32'(rsp_result), 32'(8'h36));
         check("bp.valid",  32'(rsp_valid),  32'(1));
         check("bp.ready",  32'(cmd_ready),  32'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp.idle_after_hs", 32'(cmd_ready), 32'(1));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("bp.next_taken", 32'(cmd_ready), 32'(0));
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("bp.next_result", 32'(rsp_result), 32'(8'h07));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset at MUL step 4 aborts the operation.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = 3'b111; cmd_a = 8'h0D; cmd_b = 8'h0B;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
`ifdef ALU_CMD_SEQ_MUL_EN
      check("rst.step4_src1", 32'(alu_src1), 32'(8'h8F));
`endif
      #1 rst_n = 1'b0;
      #1;
      check("rst.rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst.alu", 32'({alu_src1, alu_src2, alu_ainvert, alu_binvert, alu_op}), 32'(0));
      check("rst.cmd_ready", 32'(cmd_ready), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      check("rst.released_ready", 32'(cmd_ready), 32'(1));
      do_cmd(3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1, "add_after_rst");

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
